lfsr_stream_gen: RTL and testbench

- Parametrised Galois LFSR pseudo-random generator; successor to the fixed 16-bit LFSR.
- Adds configurable width, taps and seed, plus a step enable and runtime seed load with zero-seed protection.
- Packs output bits into OUT_BITS-wide words on a valid/ready stream, and measures the sequence period.
- Serves as a test-pattern / scrambler source feeding downstream datapaths.

---
 rtl/lfsr_pkg.sv | 14 +
 rtl/lfsr_core.sv | 31 +++
 rtl/lfsr_stream_gen.sv | 78 +++++++
 tb/tb_lfsr_stream_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: default Galois taps/seeds per width and the shared step function
package lfsr_pkg;
  localparam logic [3:0]  TAPS4  = 4'hC;
  localparam logic [3:0]  SEED4  = 4'h1;
  localparam logic [7:0]  TAPS8  = 8'hB8;
  localparam logic [7:0]  SEED8  = 8'h01;
  localparam logic [15:0] TAPS16 = 16'hB400;
  localparam logic [15:0] SEED16 = 16'hACE1;
  localparam logic [31:0] TAPS32 = 32'h8020_0003;
  localparam logic [31:0] SEED32 = 32'h0000_0001;
  function automatic logic [31:0] lfsr_step(input logic [31:0] state, input logic [31:0] taps);
    return (state >> 1) ^ (state[0] ? taps : 32'd0);
  endfunction
endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: Galois LFSR state register with step and zero-protected seed load
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = TAPS16,
  parameter logic [WIDTH-1:0] SEED  = SEED16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next,
  output logic [WIDTH-1:0] seed_val,
  output logic             load_err
);
  assign q_next   = WIDTH'(lfsr_step(32'(q), 32'(TAPS)));
  assign seed_val = (load_val == '0) ? SEED : load_val;
  // load has priority over step; a zero seed would lock the LFSR so SEED replaces it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q        <= SEED;
      load_err <= 1'b0;
    end else begin
      load_err <= load && load_val == '0;
      if (load) q <= seed_val;
      else if (step) q <= q_next;
    end
endmodule

// File: rtl/lfsr_stream_gen.sv
// lfsr_stream_gen: LFSR bit stream packed into valid/ready words with period measurement
module lfsr_stream_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = TAPS16,
  parameter logic [WIDTH-1:0] SEED     = SEED16,
  parameter int               OUT_BITS = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                en,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  output logic [WIDTH-1:0]    Q,
  output logic                bit_out,
  output logic [OUT_BITS-1:0] word,
  output logic                word_valid,
  input  logic                word_ready,
  output logic                wrap,
  output logic [WIDTH-1:0]    period,
  output logic                load_err
);
  localparam int            BW   = OUT_BITS > 1 ? $clog2(OUT_BITS) : 1;
  localparam logic [BW-1:0] LAST = BW'(OUT_BITS - 1);
  logic [WIDTH-1:0]    q_next, seed_val, start_seed, step_cnt;
  logic [OUT_BITS-1:0] collector, col_next;
  logic [BW-1:0]       bit_idx;
  logic                last, stall, step;
  assign last    = bit_idx == LAST;
  assign stall   = last & word_valid & ~word_ready;
  assign step    = en & ~load & ~stall;
  assign bit_out = Q[0];
  lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED)) u_core (
    .clk(CLK), .rst(RESET), .step(step), .load(load), .load_val(load_val),
    .q(Q), .q_next(q_next), .seed_val(seed_val), .load_err(load_err)
  );
  // collector with the current emitted bit merged in; becomes the word on the last bit
  always_comb begin
    col_next          = collector;
    col_next[bit_idx] = Q[0];
  end
  // packer and output handshake; a pending word survives loads
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      collector  <= '0;
      bit_idx    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      if (load) bit_idx <= '0;
      else if (step) begin
        collector <= col_next;
        bit_idx   <= last ? '0 : bit_idx + 1'b1;
      end
      if (step && last) begin
        word       <= col_next;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) word_valid <= 1'b0;
    end
  // period tracker: counts steps until the state returns to the seed it started from
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      start_seed <= SEED;
      step_cnt   <= '0;
      wrap       <= 1'b0;
      period     <= '0;
    end else begin
      wrap <= step && q_next == start_seed;
      if (load) begin
        start_seed <= seed_val;
        step_cnt   <= '0;
      end else if (step && q_next == start_seed) begin
        period   <= step_cnt + 1'b1;
        step_cnt <= '0;
      end else if (step) step_cnt <= step_cnt + 1'b1;
    end
endmodule

// File: tb/tb_lfsr_stream_gen.sv
// tb_lfsr_stream_gen: directed vectors with a word scoreboard over three configurations
module tb_lfsr_stream_gen;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;
  int n_tests = 0;
  int n_fail = 0;
  logic        en_a = 0, load_a = 0, ready_a = 0, mon_a = 1;
  logic [15:0] lv_a = '0;
  logic [15:0] q_a, period_a;
  logic [7:0]  word_a;
  logic        bit_a, valid_a, wrap_a, lerr_a;
  logic        en_b = 0, load_b = 0, ready_b = 0;
  logic [15:0] lv_b = '0;
  logic [15:0] q_b, period_b;
  logic [3:0]  word_b;
  logic        bit_b, valid_b, wrap_b, lerr_b;
  logic        en_c = 0, load_c = 0, ready_c = 1;
  logic [3:0]  lv_c = '0;
  logic [3:0]  q_c, period_c, word_c;
  logic        bit_c, valid_c, wrap_c, lerr_c;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  lfsr_stream_gen dut_a (
    .CLK(CLK), .RESET(RESET), .en(en_a), .load(load_a), .load_val(lv_a), .Q(q_a), .bit_out(bit_a),
    .word(word_a), .word_valid(valid_a), .word_ready(ready_a), .wrap(wrap_a), .period(period_a), .load_err(lerr_a)
  );
  lfsr_stream_gen #(.OUT_BITS(4)) dut_b (
    .CLK(CLK), .RESET(RESET), .en(en_b), .load(load_b), .load_val(lv_b), .Q(q_b), .bit_out(bit_b),
    .word(word_b), .word_valid(valid_b), .word_ready(ready_b), .wrap(wrap_b), .period(period_b), .load_err(lerr_b)
  );
  lfsr_stream_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .OUT_BITS(4)) dut_c (
    .CLK(CLK), .RESET(RESET), .en(en_c), .load(load_c), .load_val(lv_c), .Q(q_c), .bit_out(bit_c),
    .word(word_c), .word_valid(valid_c), .word_ready(ready_c), .wrap(wrap_c), .period(period_c), .load_err(lerr_c)
  );
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction
  // monitors: a word is consumed on any cycle with valid and ready both high
  always @(negedge CLK)
    if (mon_a && valid_a && ready_a) begin
      if (exp_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL word_a: got unexpected word %h expected none", word_a);
      end else chk("word_a", 32'(word_a), exp_a.pop_front());
    end
  always @(negedge CLK)
    if (valid_b && ready_b) begin
      if (exp_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL word_b: got unexpected word %h expected none", word_b);
      end else chk("word_b", 32'(word_b), exp_b.pop_front());
    end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask
  logic [3:0] seq_c [16] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                             4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};
  initial begin
    int wraps;
    RESET = 1'b1;
    #1;
    chk("rst_q", 32'(q_a), 32'hACE1);
    chk("rst_valid", 32'(valid_a), 0);
    chk("rst_word", 32'(word_a), 0);
    chk("rst_period", 32'(period_a), 0);
    chk("rst_wrap", 32'(wrap_a), 0);
    chk("rst_lerr", 32'(lerr_a), 0);
    chk("rst_q_c", 32'(q_c), 32'h1);
    tick();
    RESET = 1'b0;
    chk("bit0", 32'(bit_a), 1);
    en_a = 1;
    tick();
    chk("q1", 32'(q_a), 32'hE270);
    chk("bit1", 32'(bit_a), 0);
    tick();
    chk("q2", 32'(q_a), 32'h7138);
    chk("bit2", 32'(bit_a), 0);
    tick();
    chk("q3", 32'(q_a), 32'h389C);
    en_a = 0;
    do_reset();
    exp_b.push_back(4'h1);
    exp_b.push_back(4'hE);
    exp_b.push_back(4'h4);
    exp_b.push_back(4'hC);
    ready_b = 1;
    en_b = 1;
    repeat (3) tick();
    chk("lat_b_3", 32'(valid_b), 0);
    tick();
    chk("lat_b_4", 32'(valid_b), 1);
    chk("lat_b_word", 32'(word_b), 4'h1);
    repeat (12) tick();
    en_b = 0;
    tick();
    tick();
    chk("b_drained", exp_b.size(), 0);
    ready_b = 0;
    do_reset();
    en_b = 1;
    repeat (10) tick();
    chk("stall_q", 32'(q_b), 32'hED89);
    chk("stall_word", 32'(word_b), 4'h1);
    chk("stall_valid", 32'(valid_b), 1);
    exp_b.push_back(4'h1);
    exp_b.push_back(4'hE);
    ready_b = 1;
    tick();
    en_b = 0;
    chk("unstall_valid", 32'(valid_b), 1);
    chk("unstall_word", 32'(word_b), 4'hE);
    chk("unstall_q", 32'(q_b), 32'hC2C4);
    tick();
    chk("unstall_clear", 32'(valid_b), 0);
    chk("b2_drained", exp_b.size(), 0);
    ready_b = 0;
    do_reset();
    en_c = 1;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk($sformatf("q_c%0d", i), 32'(q_c), 32'(seq_c[i]));
      chk($sformatf("wrap_c%0d", i), 32'(wrap_c), 32'(i == 15));
    end
    chk("period_c", 32'(period_c), 15);
    en_c = 0;
    tick();
    chk("wrap_c_end", 32'(wrap_c), 0);
    do_reset();
    load_a = 1;
    lv_a = 16'h0;
    tick();
    chk("zload_q", 32'(q_a), 32'hACE1);
    chk("zload_err", 32'(lerr_a), 1);
    load_a = 0;
    tick();
    chk("zload_err_pulse", 32'(lerr_a), 0);
    en_a = 1;
    repeat (11) tick();
    chk("pend_word", 32'(word_a), 8'hE1);
    load_a = 1;
    lv_a = 16'h1234;
    tick();
    chk("ld_q", 32'(q_a), 32'h1234);
    chk("ld_valid", 32'(valid_a), 1);
    chk("ld_word", 32'(word_a), 8'hE1);
    chk("ld_err", 32'(lerr_a), 0);
    load_a = 0;
    exp_a.push_back(8'hE1);
    exp_a.push_back(8'h34);
    ready_a = 1;
    repeat (8) tick();
    en_a = 0;
    chk("ld_q8", 32'(q_a), 32'h3E32);
    tick();
    tick();
    chk("a_drained", exp_a.size(), 0);
    chk("a_idle", 32'(valid_a), 0);
    do_reset();
    mon_a = 0;
    en_a = 1;
    wraps = 0;
    repeat (65534) begin
      tick();
      if (wrap_a) wraps++;
    end
    chk("wrap_early", wraps, 0);
    tick();
    chk("full_wrap", 32'(wrap_a), 1);
    chk("full_period", 32'(period_a), 32'hFFFF);
    chk("full_q", 32'(q_a), 32'hACE1);
    en_a = 0;
    tick();
    chk("full_wrap_pulse", 32'(wrap_a), 0);
    ready_a = 0;
    mon_a = 1;
    en_a = 1;
    repeat (11) tick();
    en_a = 0;
    chk("mid_pre_valid", 32'(valid_a), 1);
    #2;
    RESET = 1'b1;
    #1;
    chk("mid_q", 32'(q_a), 32'hACE1);
    chk("mid_valid", 32'(valid_a), 0);
    chk("mid_word", 32'(word_a), 0);
    chk("mid_period", 32'(period_a), 0);
    RESET = 1'b0;
    tick();
    exp_a.push_back(8'hE1);
    ready_a = 1;
    en_a = 1;
    repeat (8) tick();
    en_a = 0;
    tick();
    tick();
    chk("mid_drained", exp_a.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
